lights_scheduler: RTL and testbench



---
 rtl/lights_pkg.sv | 39 +++
 rtl/lights_scheduler_tick_prescaler.sv | 25 ++
 rtl/lights_scheduler.sv | 155 +++++++++++++++
 tb/tb_lights_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lights_pkg.sv
// Shared definitions for the traffic-phase scheduler: light select codes,
// FSM state encoding and the round-robin direction search.
package lights_pkg;

  localparam logic [1:0] SEL_RED    = 2'd0;
  localparam logic [1:0] SEL_GREEN  = 2'd1;
  localparam logic [1:0] SEL_YELLOW = 2'd2;
  localparam logic [1:0] SEL_OFF    = 2'd3;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FLASH  = 2'd3
  } lights_state_t;

  // Next direction index modulo 3.
  function automatic logic [1:0] rr_inc(input logic [1:0] d);
    return (d == 2'd2) ? 2'd0 : d + 2'd1;
  endfunction

  // One-hot owner vector for a direction.
  function automatic logic [2:0] dir_onehot(input logic [1:0] d);
    return 3'b001 << d;
  endfunction

  // Round-robin search starting just after dir; returns dir itself when it is
  // the only (or no) pending direction.
  function automatic logic [1:0] rr_next(input logic [1:0] dir, input logic [2:0] pend);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = rr_inc(dir);
    c2 = rr_inc(c1);
    if (pend[c1])      return c1;
    else if (pend[c2]) return c2;
    else               return dir;
  endfunction

endpackage

// File: rtl/lights_scheduler_tick_prescaler.sv
// Divides the clock into timing ticks. The count restarts whenever the
// scheduler changes state so every state lasts a whole number of ticks.
module tick_prescaler #(
  parameter int TICK_DIV = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Free-running 0..TICK_DIV-1 counter, zeroed on reset or state entry.
  always_ff @(posedge clk) begin
    if (rst || restart || (count == LAST)) count <= '0;
    else                                   count <= count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/lights_scheduler.sv
// Round-robin traffic-phase scheduler driving the XYF light select inputs.
// Latches direction requests, serves one direction at a time through
// green/yellow/all-red, and supports a level-sensitive flash override.
module lights_scheduler
  import lights_pkg::*;
#(
  parameter int TICK_DIV  = 10000000,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int TW        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       flash,
  output logic [1:0] sel_0,
  output logic [1:0] sel_1,
  output logic [1:0] sel_2,
  output logic [2:0] grant,
  output logic [2:0] pending
);

  localparam logic [TW-1:0] G_MIN = TW'(GREEN_MIN);
  localparam logic [TW-1:0] G_MAX = TW'(GREEN_MAX);
  localparam logic [TW-1:0] Y_T   = TW'(YELLOW_T);
  localparam logic [TW-1:0] AR_T  = TW'(ALLRED_T);

  lights_state_t   state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic [TW-1:0]   timer_q, timer_d, elapsed;
  logic [2:0]      pend_q, pend_d, pend_set, pend_clr, others;
  logic            phase_q;
  logic            tick, restart, clear_done;
  logic [2:0][1:0] sel_n;
  logic [2:0]      grant_n;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // Any state change restarts both the prescaler and the tick timer.
  assign restart = (state_d != state_q);

  // Next-state, direction and tick-timer logic.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    timer_d    = timer_q;
    elapsed    = timer_q + TW'(1);
    clear_done = 1'b0;
    others     = pend_q & ~dir_onehot(dir_q);
    if (flash) begin
      state_d = FLASH;
    end else begin
      case (state_q)
        ALLRED: begin
          // Clearance counts up once and then waits for a request forever.
          if (tick && (timer_q < AR_T)) timer_d = elapsed;
          clear_done = (timer_q >= AR_T) || (tick && (elapsed >= AR_T));
          if (clear_done && (pend_q != 3'b000)) begin
            state_d = GREEN;
            dir_d   = rr_next(dir_q, pend_q);
          end
        end
        GREEN: begin
          if (tick) begin
            if ((elapsed >= G_MIN) && (others != 3'b000) &&
                (!req[dir_q] || (elapsed >= G_MAX)))
              state_d = YELLOW;
            else if (timer_q < G_MAX)
              timer_d = elapsed;
          end
        end
        YELLOW: begin
          if (tick) begin
            if (elapsed >= Y_T) state_d = ALLRED;
            else                timer_d = elapsed;
          end
        end
        FLASH: begin
          // Flash released: always give a full all-red clearance.
          state_d = ALLRED;
        end
        default: state_d = ALLRED;
      endcase
    end
    if (state_d != state_q) timer_d = '0;
  end

  // Request latch: the served direction is cleared on green entry and
  // cannot re-latch itself while it is green; clear beats set.
  always_comb begin
    pend_set = req;
    if (state_q == GREEN) pend_set = req & ~dir_onehot(dir_q);
    pend_clr = ((state_d == GREEN) && (state_q != GREEN)) ? dir_onehot(dir_d) : 3'b000;
    pend_d   = (pend_q | pend_set) & ~pend_clr;
  end

  // State, direction, timer, flash phase and request latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALLRED;
      dir_q   <= 2'd2;
      timer_q <= '0;
      phase_q <= 1'b0;
      pend_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      if (restart)                       phase_q <= 1'b0;
      else if ((state_q == FLASH) && tick) phase_q <= ~phase_q;
    end
  end

  // Output decode from the current state; registered below.
  always_comb begin
    sel_n   = '0;
    grant_n = 3'b000;
    case (state_q)
      GREEN, YELLOW: begin
        for (int i = 0; i < 3; i++) begin
          if (dir_q == 2'(i)) sel_n[i] = (state_q == GREEN) ? SEL_GREEN : SEL_YELLOW;
        end
        grant_n = dir_onehot(dir_q);
      end
      FLASH:   sel_n = {3{(phase_q ? SEL_OFF : SEL_YELLOW)}};
      default: sel_n = '0;
    endcase
  end

  // Registered light selects and grant vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_0 <= SEL_RED;
      sel_1 <= SEL_RED;
      sel_2 <= SEL_RED;
      grant <= 3'b000;
    end else begin
      sel_0 <= sel_n[0];
      sel_1 <= sel_n[1];
      sel_2 <= sel_n[2];
      grant <= grant_n;
    end
  end

  assign pending = pend_q;

endmodule

// File: tb/tb_lights_scheduler.sv
// Directed bench for lights_scheduler with per-cycle expected outputs.
module tb_lights_scheduler;
  import lights_pkg::*;

  localparam int W = 29;   // {cyc[15:0], pchk, pend[2:0], grant[2:0], sel[5:0]}
  localparam int N = 128;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [2:0] req   = 3'b000;
  logic       flash = 1'b0;
  logic [1:0] sel_0, sel_1, sel_2;
  logic [2:0] grant, pending;

  lights_scheduler #(
    .TICK_DIV(4), .GREEN_MIN(2), .GREEN_MAX(4), .YELLOW_T(1), .ALLRED_T(1), .TW(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .flash(flash),
    .sel_0(sel_0), .sel_1(sel_1), .sel_2(sel_2),
    .grant(grant), .pending(pending)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_item;
  int           n_checks = 0;
  int           n_fail   = 0;
  string        scen     = "none";

  logic [5:0] e_sel [N];
  logic [2:0] e_gnt [N];
  logic [2:0] e_pnd [N];
  logic       e_pchk[N];

  // Monitor: compare every expectation whose cycle has come.
  always @(negedge clk) begin
    while ((exp_q.size() > 0) && (int'(exp_q[0][28:13]) <= cyc)) begin
      mon_item = exp_q.pop_front();
      n_checks++;
      if (int'(mon_item[28:13]) != cyc) begin
        n_fail++;
        $display("FAIL %s missed_check cyc=%0d now=%0d", scen, int'(mon_item[28:13]), cyc);
      end else begin
        if (({sel_2, sel_1, sel_0} !== mon_item[5:0]) || (grant !== mon_item[8:6])) begin
          n_fail++;
          $display("FAIL %s lights cyc=%0d got sel210=%b grant=%b exp sel210=%b grant=%b",
                   scen, cyc, {sel_2, sel_1, sel_0}, grant, mon_item[5:0], mon_item[8:6]);
        end
        if (mon_item[12]) begin
          n_checks++;
          if (pending !== mon_item[11:9]) begin
            n_fail++;
            $display("FAIL %s pending cyc=%0d got=%b exp=%b", scen, cyc, pending, mon_item[11:9]);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [5:0] sel_one(input int d, input logic [1:0] v);
    return 6'(v) << (2 * d);
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < N; i++) begin
      e_sel[i] = '0; e_gnt[i] = '0; e_pnd[i] = '0; e_pchk[i] = 1'b0;
    end
  endtask

  task automatic fill_out(input int a, input int b, input logic [5:0] s, input logic [2:0] g);
    for (int i = a; i <= b; i++) begin
      e_sel[i] = s; e_gnt[i] = g;
    end
  endtask

  task automatic fill_pend(input int a, input int b, input logic [2:0] p);
    for (int i = a; i <= b; i++) begin
      e_pnd[i] = p; e_pchk[i] = 1'b1;
    end
  endtask

  task automatic commit(input int base, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({16'(base + k), e_pchk[k], e_pnd[k], e_gnt[k], e_sel[k]});
  endtask

  task automatic goto(input int abs_cyc);
    while (cyc < abs_cyc) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() > 0) && (guard < 500)) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s drain_timeout left=%0d", scen, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Two reset edges; returns the cycle index of the last reset edge.
  task automatic do_reset(output int base);
    rst = 1'b1; req = 3'b000; flash = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst  = 1'b0;
    base = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [5:0] all_y, all_off;
    all_y   = {3{SEL_YELLOW}};
    all_off = {3{SEL_OFF}};

    // 1: idle after reset stays all-red.
    scen = "s1_idle";
    do_reset(r); clear_exp();
    fill_out(0, 40, 6'b0, 3'b000); fill_pend(0, 40, 3'b000);
    commit(r, 41);
    goto(r + 41); drain();

    // 2: single request pulse after clearance, green held forever.
    scen = "s2_pulse";
    do_reset(r); clear_exp();
    fill_out(0, 12, 6'b0, 3'b000);
    fill_out(13, 112, sel_one(1, SEL_GREEN), 3'b010);
    fill_pend(0, 10, 3'b000); fill_pend(11, 11, 3'b010); fill_pend(12, 112, 3'b000);
    commit(r, 113);
    goto(r + 10); req = 3'b010;
    goto(r + 11); req = 3'b000;
    goto(r + 113); drain();

    // 3: all three requested, round robin 0,1,2 then 0 again.
    scen = "s3_round_robin";
    do_reset(r); clear_exp();
    req = 3'b111;
    fill_out(0, 4, 6'b0, 3'b000);
    fill_out(5, 12, sel_one(0, SEL_GREEN), 3'b001);
    fill_out(13, 16, sel_one(0, SEL_YELLOW), 3'b001);
    fill_out(17, 20, 6'b0, 3'b000);
    fill_out(21, 28, sel_one(1, SEL_GREEN), 3'b010);
    fill_out(29, 32, sel_one(1, SEL_YELLOW), 3'b010);
    fill_out(33, 36, 6'b0, 3'b000);
    fill_out(37, 44, sel_one(2, SEL_GREEN), 3'b100);
    fill_out(45, 48, sel_one(2, SEL_YELLOW), 3'b100);
    fill_out(49, 52, 6'b0, 3'b000);
    fill_out(53, 60, sel_one(0, SEL_GREEN), 3'b001);
    fill_pend(0, 0, 3'b000); fill_pend(1, 3, 3'b111); fill_pend(4, 19, 3'b110);
    fill_pend(20, 24, 3'b100); fill_pend(25, 35, 3'b101); fill_pend(36, 51, 3'b001);
    fill_pend(52, 60, 3'b000);
    commit(r, 61);
    goto(r + 1);  req = 3'b000;
    goto(r + 24); req = 3'b001;
    goto(r + 25); req = 3'b000;
    goto(r + 61); drain();

    // 4: held request on the green direction extends it to the maximum.
    scen = "s4_green_max";
    do_reset(r); clear_exp();
    req = 3'b001;
    fill_out(0, 4, 6'b0, 3'b000);
    fill_out(5, 20, sel_one(0, SEL_GREEN), 3'b001);
    fill_out(21, 24, sel_one(0, SEL_YELLOW), 3'b001);
    fill_out(25, 28, 6'b0, 3'b000);
    fill_out(29, 36, sel_one(2, SEL_GREEN), 3'b100);
    fill_out(37, 40, sel_one(2, SEL_YELLOW), 3'b100);
    fill_out(41, 44, 6'b0, 3'b000);
    fill_out(45, 48, sel_one(0, SEL_GREEN), 3'b001);
    fill_pend(0, 0, 3'b000); fill_pend(1, 3, 3'b001); fill_pend(4, 6, 3'b000);
    fill_pend(7, 20, 3'b100); fill_pend(21, 27, 3'b101); fill_pend(28, 43, 3'b001);
    fill_pend(44, 48, 3'b000);
    commit(r, 49);
    goto(r + 6); req = 3'b101;
    goto(r + 7); req = 3'b001;
    goto(r + 49); req = 3'b000; drain();

    // 5: flash mid-green, then clearance and round robin resumes at dir 2.
    scen = "s5_flash";
    do_reset(r); clear_exp();
    req = 3'b010;
    fill_out(0, 4, 6'b0, 3'b000);
    fill_out(5, 11, sel_one(1, SEL_GREEN), 3'b010);
    fill_out(12, 15, all_y, 3'b000);
    fill_out(16, 19, all_off, 3'b000);
    fill_out(20, 23, all_y, 3'b000);
    fill_out(24, 27, all_off, 3'b000);
    fill_out(28, 31, 6'b0, 3'b000);
    fill_out(32, 39, sel_one(2, SEL_GREEN), 3'b100);
    fill_out(40, 43, sel_one(2, SEL_YELLOW), 3'b100);
    fill_out(44, 47, 6'b0, 3'b000);
    fill_out(48, 50, sel_one(0, SEL_GREEN), 3'b001);
    fill_pend(0, 0, 3'b000); fill_pend(1, 3, 3'b010); fill_pend(4, 8, 3'b000);
    fill_pend(9, 30, 3'b101); fill_pend(31, 46, 3'b001); fill_pend(47, 50, 3'b000);
    commit(r, 51);
    goto(r + 1);  req = 3'b000;
    goto(r + 8);  req = 3'b101;
    goto(r + 9);  req = 3'b000;
    goto(r + 10); flash = 1'b1;
    goto(r + 26); flash = 1'b0;
    goto(r + 51); drain();

    // 6: reset (with flash also high) during yellow clears everything.
    scen = "s6_reset_yellow";
    do_reset(r); clear_exp();
    req = 3'b010;
    fill_out(0, 4, 6'b0, 3'b000);
    fill_out(5, 12, sel_one(1, SEL_GREEN), 3'b010);
    fill_out(13, 13, sel_one(1, SEL_YELLOW), 3'b010);
    fill_out(14, 44, 6'b0, 3'b000);
    fill_pend(0, 0, 3'b000); fill_pend(1, 3, 3'b010); fill_pend(4, 6, 3'b000);
    fill_pend(7, 13, 3'b101); fill_pend(14, 44, 3'b000);
    commit(r, 45);
    goto(r + 1);  req = 3'b000;
    goto(r + 6);  req = 3'b101;
    goto(r + 7);  req = 3'b000;
    goto(r + 13); rst = 1'b1; flash = 1'b1;
    goto(r + 14); rst = 1'b0; flash = 1'b0;
    goto(r + 45); drain();

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
